mem_access_arbiter: RTL and testbench

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_access_arbiter_pkg.sv | 25 ++
 rtl/mem_access_arbiter_if.sv | 42 ++++
 rtl/mem_access_arbiter_rr_arbiter2.sv | 24 ++
 rtl/mem_access_arbiter.sv | 113 +++++++++++
 tb/tb_mem_access_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the two-requester memory access arbiter.
//   - DATA_W_DEF / ADDR_W_DEF : default byte and address widths (4 x 8 memory)
//   - N_REQ                   : number of requesters (fixed at 2)
//   - state_e                 : FSM state encoding (IDLE, SETUP, STROBE, SAMPLE, HOLD)
//   - onehot2_idx()           : index of the set bit in a 2-bit one-hot grant
package mem_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int N_REQ      = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  // Index of the winning requester for a one-hot 2-bit grant.
  function automatic logic onehot2_idx(input logic [N_REQ-1:0] onehot);
    return onehot[1];
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: bundle of requester-side and memory-side signals.
//   Requester side : req, we, addr, wdata (in to arbiter); done, rdata, busy (out)
//   Memory side    : mem_addr, mem_data, mem_store (out to memory); mem_q (in)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory system)
//
// Handshake: a requester raises req[i] with we/addr/wdata stable; the request
// is taken on the first rising edge where the FSM is IDLE and it wins
// arbitration (the accept edge). After that edge the requester's inputs are
// don't-care. done[i] pulses for one cycle three clocks after the accept edge
// (rdata valid in that cycle for reads); the requester must drop req[i]
// during its done cycle, otherwise it is treated as a new request.
interface mem_access_arbiter_if import mem_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       rdata;
  logic                    busy;

  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_data;
  logic                    mem_store;
  logic [DATA_W-1:0]       mem_q;

  modport slave (
    input  req, we, addr, wdata, mem_q,
    output done, rdata, busy, mem_addr, mem_data, mem_store
  );

  modport master (
    output req, we, addr, wdata, mem_q,
    input  done, rdata, busy, mem_addr, mem_data, mem_store
  );

endinterface

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way winner selection.
// Ports:
//   req        [1:0] in  - request bits
//   last_grant       in  - index of the requester granted last time
//   grant      [1:0] out - one-hot winner (zero when no request)
// A lone request always wins. On a tie the requester that was not granted
// last wins; tying last_grant high makes requester 0 win every tie.
module rr_arbiter2 import mem_arb_pkg::*; (
  input  logic [N_REQ-1:0] req,
  input  logic             last_grant,
  output logic [N_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: serialises two requesters onto a single-port memory.
// Ports:
//   clk, rst_n     - clock and synchronous active-low reset
//   bus (slave)    - requester and memory signals, see mem_access_arbiter_if
//   state_dbg[2:0] - current FSM state (mem_arb_pkg::state_e encoding)
// Each transaction walks IDLE -> SETUP -> STROBE (write) or SAMPLE (read)
// -> HOLD -> IDLE, so done arrives three clocks after the accept edge and
// back-to-back transactions run one per four cycles.
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; without
// it requester 0 wins every tie and no last-grant state is kept.
module mem_access_arbiter import mem_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_arbiter_if.slave bus,
  output logic [2:0]          state_dbg
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] SETUP  = ST_SETUP;
  localparam logic [2:0] STROBE = ST_STROBE;
  localparam logic [2:0] SAMPLE = ST_SAMPLE;
  localparam logic [2:0] HOLD   = ST_HOLD;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [N_REQ-1:0]  win;
  logic [N_REQ-1:0]  grant_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              last_sel;
  logic              accept;
  logic              win_idx;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Resets to 1 so that requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= win_idx;
    end
  end

  assign last_sel = last_q;
`else
  assign last_sel = 1'b1;
`endif

  rr_arbiter2 u_arb (
    .req        (bus.req),
    .last_grant (last_sel),
    .grant      (win)
  );

  assign accept  = (state == IDLE) && (|bus.req);
  assign win_idx = onehot2_idx(win);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = SETUP;
      SETUP:   state_nxt = we_q ? STROBE : SAMPLE;
      STROBE:  state_nxt = HOLD;
      SAMPLE:  state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The winner's request is captured once at the accept edge; later changes
  // on the requester inputs cannot disturb the transaction in flight. The
  // address/data registers are not cleared on return to IDLE so the memory
  // bus keeps its last values between transactions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant_q <= win;
        we_q    <= bus.we[win_idx];
        addr_q  <= bus.addr[win_idx*ADDR_W +: ADDR_W];
        data_q  <= bus.wdata[win_idx*DATA_W +: DATA_W];
      end
      if (state == SAMPLE) begin
        rdata_q <= bus.mem_q;
      end
    end
  end

  // Strobe, done and busy decode straight from the state register, so a
  // reset that forces IDLE drops them in the very next cycle.
  assign bus.mem_store = (state == STROBE);
  assign bus.done      = (state == HOLD) ? grant_q : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.rdata     = rdata_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed bench for mem_access_arbiter.
// A behavioural 4x8 memory sits on the memory side. A vector table drives
// single transactions and ties; hand-written sequences cover input changes
// after accept and reset during STROBE. Build with or without MEM_ARB_RR_EN.
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [2:0] state_dbg;
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_access_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [4];
  always @(posedge clk) if (bus.mem_store) mem[bus.mem_addr] <= bus.mem_data;
  assign bus.mem_q = mem[bus.mem_addr];

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_errors;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  addr;    // {addr1, addr0}
    logic [15:0] wdata;   // {wdata1, wdata0}
    logic [1:0]  grant;   // expected winner
    logic [7:0]  rd;      // expected rdata when the winner reads
    bit          chk_rd;
  } vec_t;

`ifdef MEM_ARB_RR_EN
  localparam logic [1:0] TIE_B = 2'b10;
`else
  localparam logic [1:0] TIE_B = 2'b01;
`endif

  vec_t vecs[14];
  int   last_done;

  // ---------------- driver ----------------
  // Starts at a negedge with the DUT in IDLE and ends at the negedge of the
  // IDLE cycle that follows HOLD, so consecutive calls run back-to-back.
  task automatic run_txn(input vec_t v, input bit scramble, input string tag);
    int            w;
    logic          exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    w      = v.grant[1] ? 1 : 0;
    exp_we = v.we[w];
    exp_a  = v.addr[w*AW +: AW];
    exp_d  = v.wdata[w*DW +: DW];
    if (v.chk_rd) exp_q.push_back(v.rd);

    check({tag, " busy_idle"}, bus.busy, 0);
    bus.req   = v.req;
    bus.we    = v.we;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);  // cycle 1: SETUP
    check({tag, " c1_state"}, state_dbg, ST_SETUP);
    check({tag, " c1_addr"}, bus.mem_addr, exp_a);
    check({tag, " c1_data"}, bus.mem_data, exp_d);
    check({tag, " c1_store"}, bus.mem_store, 0);
    check({tag, " c1_busy"}, bus.busy, 1);
    if (scramble) begin
      bus.req   = 2'b00;
      bus.we    = ~v.we;
      bus.addr  = ~v.addr;
      bus.wdata = ~v.wdata;
    end
    @(negedge clk);  // cycle 2: STROBE or SAMPLE
    check({tag, " c2_state"}, state_dbg, exp_we ? ST_STROBE : ST_SAMPLE);
    check({tag, " c2_store"}, bus.mem_store, exp_we);
    check({tag, " c2_addr"}, bus.mem_addr, exp_a);
    check({tag, " c2_done"}, bus.done, 0);
    @(negedge clk);  // cycle 3: HOLD
    check({tag, " c3_done"}, bus.done, v.grant);
    check({tag, " c3_store"}, bus.mem_store, 0);
    check({tag, " c3_data"}, bus.mem_data, exp_d);
    if (v.chk_rd) check({tag, " c3_rdata"}, bus.rdata, exp_q.pop_front());
    last_done = cyc;
    bus.req = 2'b00;
    @(negedge clk);  // back in IDLE
    check({tag, " c4_done"}, bus.done, 0);
    check({tag, " c4_addr_kept"}, bus.mem_addr, exp_a);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int   prev_done;
    logic [1:0] done_seen;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.we   = '0;
    bus.addr = '0;
    bus.wdata = '0;

    //            req    we     {a1,a0}  {d1,d0}   grant  rd    chk
    vecs[0]  = '{2'b11, 2'b11, 4'b0100, 16'h5B5A, 2'b01, 8'h00, 1'b0};
    vecs[1]  = '{2'b11, 2'b11, 4'b0100, 16'h5B5A, TIE_B, 8'h00, 1'b0};
    vecs[2]  = '{2'b11, 2'b11, 4'b0100, 16'h5B5A, 2'b01, 8'h00, 1'b0};
    vecs[3]  = '{2'b11, 2'b11, 4'b0100, 16'h5B5A, TIE_B, 8'h00, 1'b0};
    vecs[4]  = '{2'b01, 2'b01, 4'b0010, 16'h00A5, 2'b01, 8'h00, 1'b0};
    vecs[5]  = '{2'b10, 2'b00, 4'b1000, 16'h0000, 2'b10, 8'hA5, 1'b1};
    vecs[6]  = '{2'b01, 2'b01, 4'b0000, 16'h0011, 2'b01, 8'h00, 1'b0};
    vecs[7]  = '{2'b10, 2'b10, 4'b0100, 16'h2200, 2'b10, 8'h00, 1'b0};
    vecs[8]  = '{2'b01, 2'b01, 4'b0010, 16'h0033, 2'b01, 8'h00, 1'b0};
    vecs[9]  = '{2'b10, 2'b10, 4'b1100, 16'h4400, 2'b10, 8'h00, 1'b0};
    vecs[10] = '{2'b01, 2'b00, 4'b0000, 16'h0000, 2'b01, 8'h11, 1'b1};
    vecs[11] = '{2'b10, 2'b00, 4'b0100, 16'h0000, 2'b10, 8'h22, 1'b1};
    vecs[12] = '{2'b01, 2'b00, 4'b0010, 16'h0000, 2'b01, 8'h33, 1'b1};
    vecs[13] = '{2'b10, 2'b00, 4'b1100, 16'h0000, 2'b10, 8'h44, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_store", bus.mem_store, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_data", bus.mem_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: ties from reset, single write/read, back-to-back fill and readback
    for (int i = 0; i < 14; i++) begin
      prev_done = last_done;
      run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));
      if (i > 0) check($sformatf("vec%0d spacing", i), last_done - prev_done, 4);
    end

    // Inputs dropped/changed right after accept: write must still complete
    v = '{2'b01, 2'b01, 4'b0011, 16'h0077, 2'b01, 8'h00, 1'b0};
    run_txn(v, 1'b1, "drop_wr");
    v = '{2'b10, 2'b00, 4'b1100, 16'h0000, 2'b10, 8'h77, 1'b1};
    run_txn(v, 1'b0, "drop_rd");

    // Reset during STROBE of a requester-0 write
    bus.req   = 2'b01;
    bus.we    = 2'b01;
    bus.addr  = 4'b0000;
    bus.wdata = 16'h0099;
    @(posedge clk);
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    check("abort strobe_before", bus.mem_store, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort store", bus.mem_store, 0);
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort rdata_clr", bus.rdata, 0);
    check("abort addr_clr", bus.mem_addr, 0);
    rst_n = 1'b1;
    done_seen = '0;
    repeat (4) begin
      @(negedge clk);
      done_seen = done_seen | bus.done;
    end
    check("abort no_done", done_seen, 0);

    // Tie after reset: last-grant restored, requester 0 wins
    v = '{2'b11, 2'b00, 4'b0011, 16'h0000, 2'b01, 8'h77, 1'b1};
    run_txn(v, 1'b0, "post_rst_tie");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
